seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 132 +++++++++++++
 tb/tb_seg_capture.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Captures a multiplexed active-low 7-segment display into a 16-bit word.
// A digit is captured once per steady interval of {an,seg}, after STABLE_CYCLES edges.
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        err
);

  typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  // Returns {valid, blank, nibble}; anything else is an invalid pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    case (p)
      7'b0000001: decode_seg = {2'b10, 4'h0};
      7'b1001111: decode_seg = {2'b10, 4'h1};
      7'b0010010: decode_seg = {2'b10, 4'h2};
      7'b0000110: decode_seg = {2'b10, 4'h3};
      7'b1001100: decode_seg = {2'b10, 4'h4};
      7'b0100100: decode_seg = {2'b10, 4'h5};
      7'b0100000: decode_seg = {2'b10, 4'h6};
      7'b0001111: decode_seg = {2'b10, 4'h7};
      7'b0000000: decode_seg = {2'b10, 4'h8};
      7'b0000100: decode_seg = {2'b10, 4'h9};
      7'b0001000: decode_seg = {2'b10, 4'hA};
      7'b1100000: decode_seg = {2'b10, 4'hB};
      7'b0110001: decode_seg = {2'b10, 4'hC};
      7'b1000010: decode_seg = {2'b10, 4'hD};
      7'b0110000: decode_seg = {2'b10, 4'hE};
      7'b0111000: decode_seg = {2'b10, 4'hF};
      7'b1111111: decode_seg = {2'b01, 4'h0};
      default:    decode_seg = {2'b00, 4'h0};
    endcase
  endfunction

  state_t      state_r;
  logic [10:0] sample_r;
  logic [7:0]  cnt_r;
  logic        cap_done_r;

  logic [10:0] in_s;
  logic        same_s;
  logic        one_digit_s;
  logic [1:0]  idx_s;
  logic [5:0]  dec_s;
  logic        cap_s;
  logic [3:0]  dv_next_s;

  // Capture qualification and digit selection from the current inputs.
  always_comb begin
    in_s        = {an, seg};
    same_s      = (in_s == sample_r);
    dec_s       = decode_seg(seg);
    one_digit_s = 1'b1;
    idx_s       = 2'd0;
    case (an)
      4'b1110: idx_s = 2'd0;
      4'b1101: idx_s = 2'd1;
      4'b1011: idx_s = 2'd2;
      4'b0111: idx_s = 2'd3;
      default: one_digit_s = 1'b0;
    endcase
    cap_s     = same_s && (cnt_r == CNT_LAST) && one_digit_s && !cap_done_r;
    dv_next_s = digit_valid | (4'b0001 << idx_s);
  end

  // Sampling, stability counting, capture and frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r    <= 11'h7FF;
      cnt_r       <= 8'd0;
      cap_done_r  <= 1'b0;
      state_r     <= COLLECT;
      value       <= 16'h0000;
      digit_valid <= 4'b0000;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      sample_r    <= in_s;
      frame_valid <= 1'b0;
      if (clr) begin
        cnt_r       <= 8'd0;
        cap_done_r  <= 1'b0;
        state_r     <= COLLECT;
        value       <= 16'h0000;
        digit_valid <= 4'b0000;
        err         <= 1'b0;
      end else begin
        if (!same_s) begin
          cnt_r      <= 8'd0;
          cap_done_r <= 1'b0;
        end else if (cnt_r < CNT_MAX) begin
          cnt_r <= cnt_r + 8'd1;
        end else begin
          cnt_r <= cnt_r;
        end
        case (state_r)
          DONE:    state_r <= COLLECT;
          COLLECT: state_r <= COLLECT;
          default: state_r <= COLLECT;
        endcase
        if (cap_s) begin
          cap_done_r <= 1'b1;
          if (dec_s[5]) begin
            value[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
            // A completed frame is reported by the pulse, never as all-ones.
            if (dv_next_s == 4'b1111) begin
              digit_valid <= 4'b0000;
              frame_valid <= 1'b1;
              state_r     <= DONE;
            end else begin
              digit_valid <= dv_next_s;
            end
          end else if (!dec_s[4]) begin
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Directed self-checking bench for seg_capture with hand-computed expectations.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        clr;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P9 = 7'b0000100,
                         PB = 7'b1100000, PE = 7'b0110000, PF = 7'b0111000,
                         BLANK = 7'b1111111, BAD = 7'b1010101;

  seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clr(clr),
    .value(value), .digit_valid(digit_valid), .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    @(negedge clk);
    an  = a;
    seg = s;
  endtask

  task automatic idle(input int n);
    drive(4'b1111, BLANK);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; an = 4'b1111; seg = BLANK;
    #3;
    n_total++; if (value !== 16'h0000) $display("FAIL reset_value got=%h exp=0000", value); else n_pass++;
    n_total++; if (digit_valid !== 4'b0000) $display("FAIL reset_dv got=%b exp=0000", digit_valid); else n_pass++;
    n_total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv got=%b exp=0", frame_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_digit();
    drive(4'b1110, P3);
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 3) begin
        n_total++; if (digit_valid !== 4'b0000) $display("FAIL single_early got dv=%b exp=0000", digit_valid); else n_pass++;
      end
      if (e == 4 || e == 7) begin
        n_total++; if (value !== 16'h0003) $display("FAIL single_value e=%0d got=%h exp=0003", e, value); else n_pass++;
        n_total++; if (digit_valid !== 4'b0001) $display("FAIL single_dv e=%0d got=%b exp=0001", e, digit_valid); else n_pass++;
      end
    end
    idle(1);
    @(negedge clk); clr = 1'b1;
    tick();
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic do_scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input logic [15:0] exp_v, input string nm);
    logic [6:0] pats [4];
    logic [3:0] ans  [4];
    int fv_count;
    int dv_full;
    pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
    ans[0] = 4'b1110; ans[1] = 4'b1101; ans[2] = 4'b1011; ans[3] = 4'b0111;
    fv_count = 0;
    dv_full  = 0;
    for (int d = 0; d < 4; d++) begin
      drive(ans[d], pats[d]);
      for (int c = 0; c < 6; c++) begin
        tick();
        if (frame_valid === 1'b1) fv_count++;
        if (digit_valid === 4'b1111) dv_full++;
        if (d == 3 && c == 4) begin
          n_total++; if (frame_valid !== 1'b1) $display("FAIL %s_fv got=%b exp=1", nm, frame_valid); else n_pass++;
          n_total++; if (value !== exp_v) $display("FAIL %s_value got=%h exp=%h", nm, value, exp_v); else n_pass++;
          n_total++; if (digit_valid !== 4'b0000) $display("FAIL %s_dv got=%b exp=0000", nm, digit_valid); else n_pass++;
        end
      end
    end
    n_total++; if (fv_count != 1) $display("FAIL %s_fv_pulses got=%0d exp=1", nm, fv_count); else n_pass++;
    n_total++; if (dv_full != 0) $display("FAIL %s_dv_full got=%0d exp=0", nm, dv_full); else n_pass++;
  endtask

  task automatic test_scan();
    do_scan(PF, PE, PE, PB, 16'hBEEF, "scan");
  endtask

  task automatic test_short_hold();
    drive(4'b1110, P9);
    repeat (3) tick();
    idle(6);
    n_total++; if (digit_valid !== 4'b0000) $display("FAIL short_dv got=%b exp=0000", digit_valid); else n_pass++;
    n_total++; if (value !== 16'hBEEF) $display("FAIL short_value got=%h exp=BEEF", value); else n_pass++;
  endtask

  task automatic test_err();
    drive(4'b1101, BAD);
    for (int e = 0; e < 6; e++) begin
      tick();
      if (e == 3) begin
        n_total++; if (err !== 1'b0) $display("FAIL err_early got=%b exp=0", err); else n_pass++;
      end
    end
    n_total++; if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err); else n_pass++;
    n_total++; if (digit_valid !== 4'b0000) $display("FAIL err_dv got=%b exp=0000", digit_valid); else n_pass++;
    drive(4'b1101, BLANK);
    repeat (6) tick();
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err); else n_pass++;
    n_total++; if (digit_valid !== 4'b0000) $display("FAIL blank_dv got=%b exp=0000", digit_valid); else n_pass++;
    n_total++; if (value !== 16'hBEEF) $display("FAIL blank_value got=%h exp=BEEF", value); else n_pass++;
  endtask

  task automatic test_multi_and_clr();
    drive(4'b1100, P0);
    repeat (6) tick();
    n_total++; if (digit_valid !== 4'b0000) $display("FAIL multi_dv got=%b exp=0000", digit_valid); else n_pass++;
    n_total++; if (value !== 16'hBEEF) $display("FAIL multi_value got=%h exp=BEEF", value); else n_pass++;
    drive(4'b1110, P0);
    repeat (4) tick();
    @(negedge clk); clr = 1'b1;
    tick();
    n_total++; if (value !== 16'h0000) $display("FAIL clr_value got=%h exp=0000", value); else n_pass++;
    n_total++; if (digit_valid !== 4'b0000) $display("FAIL clr_dv got=%b exp=0000", digit_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL clr_err got=%b exp=0", err); else n_pass++;
    n_total++; if (frame_valid !== 1'b0) $display("FAIL clr_fv got=%b exp=0", frame_valid); else n_pass++;
    @(negedge clk); clr = 1'b0;
    an = 4'b1111; seg = BLANK;
    repeat (2) tick();
  endtask

  task automatic test_reset_midframe();
    drive(4'b1110, P1);
    repeat (6) tick();
    drive(4'b1101, P2);
    repeat (6) tick();
    n_total++; if (value !== 16'h0021) $display("FAIL mid_value got=%h exp=0021", value); else n_pass++;
    n_total++; if (digit_valid !== 4'b0011) $display("FAIL mid_dv got=%b exp=0011", digit_valid); else n_pass++;
    rst_n = 1'b0;
    #2;
    n_total++; if (value !== 16'h0000) $display("FAIL async_value got=%h exp=0000", value); else n_pass++;
    n_total++; if (digit_valid !== 4'b0000) $display("FAIL async_dv got=%b exp=0000", digit_valid); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    do_scan(P1, P2, P3, P4, 16'h4321, "rescan");
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_scan();
    test_short_hold();
    test_err();
    test_multi_and_clr();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
